// File: rtl/hazard_pkg.sv
// Shared encodings for the P5 hazard unit: forwarding selects and Tuse/Tnew constants.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] T_LW  = 2'd2;
    localparam logic [1:0] T_ALU = 2'd1;
    localparam logic [1:0] T_JAL = 2'd0;

endpackage

// File: rtl/hazard_fwd_pick.sv
// Nearest-stage-first forwarding select for one source register.
module hazard_fwd_pick
    import hazard_pkg::*;
#(
    parameter int unsigned NREG_W = 5,
    parameter int unsigned T_W    = 2
) (
    input  logic [NREG_W-1:0] i_src,
    input  logic [NREG_W-1:0] i_dst_e,
    input  logic [T_W-1:0]    i_tnew_e,
    input  logic [NREG_W-1:0] i_dst_m,
    input  logic [T_W-1:0]    i_tnew_m,
    input  logic [NREG_W-1:0] i_dst_w,
    output fwd_sel_e          o_sel
);

    // A younger match that is not ready yet hides any older match.
    always_comb begin
        o_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_src == i_dst_e) begin
                if (i_tnew_e == '0) o_sel = FWD_E;
            end else if (i_src == i_dst_m) begin
                if (i_tnew_m == '0) o_sel = FWD_M;
            end else if (i_src == i_dst_w) begin
                o_sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Consumer-side hazard unit: tracks dst/Tnew through E/M/W, drives D stall and forwarding selects.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREG_W = 5,
    parameter int unsigned T_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREG_W-1:0] rs_d,
    input  logic [NREG_W-1:0] rt_d,
    input  logic [T_W-1:0]    tuse_rs_d,
    input  logic [T_W-1:0]    tuse_rt_d,
    input  logic [NREG_W-1:0] dst_d,
    input  logic [T_W-1:0]    tnew_d,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m
);

    logic [NREG_W-1:0] r_dst_e, r_rs_e, r_rt_e;
    logic [T_W-1:0]    r_tnew_e;
    logic [NREG_W-1:0] r_dst_m, r_rt_m;
    logic [T_W-1:0]    r_tnew_m;
    logic [NREG_W-1:0] r_dst_w;

    logic     w_stall_rs, w_stall_rt;
    fwd_sel_e w_sel_rs_d, w_sel_rt_d, w_sel_rs_e, w_sel_rt_e, w_sel_rt_m;

    always_comb begin
        w_stall_rs = (rs_d != '0) &&
                     ((rs_d == r_dst_e && tuse_rs_d < r_tnew_e) ||
                      (rs_d == r_dst_m && tuse_rs_d < r_tnew_m));
        w_stall_rt = (rt_d != '0) &&
                     ((rt_d == r_dst_e && tuse_rt_d < r_tnew_e) ||
                      (rt_d == r_dst_m && tuse_rt_d < r_tnew_m));
        stall      = w_stall_rs || w_stall_rt;
    end

    // M and W always advance; only E takes a bubble on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dst_e  <= '0;
            r_tnew_e <= '0;
            r_rs_e   <= '0;
            r_rt_e   <= '0;
            r_dst_m  <= '0;
            r_tnew_m <= '0;
            r_rt_m   <= '0;
            r_dst_w  <= '0;
        end else begin
            if (stall) begin
                r_dst_e  <= '0;
                r_tnew_e <= '0;
                r_rs_e   <= '0;
                r_rt_e   <= '0;
            end else begin
                r_dst_e  <= dst_d;
                r_tnew_e <= tnew_d;
                r_rs_e   <= rs_d;
                r_rt_e   <= rt_d;
            end
            r_dst_m  <= r_dst_e;
            r_tnew_m <= (r_tnew_e == '0) ? '0 : r_tnew_e - T_W'(1);
            r_rt_m   <= r_rt_e;
            r_dst_w  <= r_dst_m;
        end
    end

    hazard_fwd_pick #(.NREG_W(NREG_W), .T_W(T_W)) u_pick_rs_d (
        .i_src(rs_d), .i_dst_e(r_dst_e), .i_tnew_e(r_tnew_e),
        .i_dst_m(r_dst_m), .i_tnew_m(r_tnew_m), .i_dst_w(r_dst_w), .o_sel(w_sel_rs_d)
    );

    hazard_fwd_pick #(.NREG_W(NREG_W), .T_W(T_W)) u_pick_rt_d (
        .i_src(rt_d), .i_dst_e(r_dst_e), .i_tnew_e(r_tnew_e),
        .i_dst_m(r_dst_m), .i_tnew_m(r_tnew_m), .i_dst_w(r_dst_w), .o_sel(w_sel_rt_d)
    );

    // E and M consumers only look at older stages, so the unused stages are tied off.
    hazard_fwd_pick #(.NREG_W(NREG_W), .T_W(T_W)) u_pick_rs_e (
        .i_src(r_rs_e), .i_dst_e('0), .i_tnew_e('0),
        .i_dst_m(r_dst_m), .i_tnew_m(r_tnew_m), .i_dst_w(r_dst_w), .o_sel(w_sel_rs_e)
    );

    hazard_fwd_pick #(.NREG_W(NREG_W), .T_W(T_W)) u_pick_rt_e (
        .i_src(r_rt_e), .i_dst_e('0), .i_tnew_e('0),
        .i_dst_m(r_dst_m), .i_tnew_m(r_tnew_m), .i_dst_w(r_dst_w), .o_sel(w_sel_rt_e)
    );

    hazard_fwd_pick #(.NREG_W(NREG_W), .T_W(T_W)) u_pick_rt_m (
        .i_src(r_rt_m), .i_dst_e('0), .i_tnew_e('0),
        .i_dst_m('0), .i_tnew_m('0), .i_dst_w(r_dst_w), .o_sel(w_sel_rt_m)
    );

    always_comb begin
        fwd_rs_d = w_sel_rs_d;
        fwd_rt_d = w_sel_rt_d;
        fwd_rs_e = w_sel_rs_e;
        fwd_rt_e = w_sel_rt_e;
        fwd_rt_m = (w_sel_rt_m == FWD_W);
    end

endmodule
